// File: rtl/rx.sv
// 8N1 UART receiver driven by a shared 16x baud tick; holds the last good byte and flags rda.
// Define RX_FERR_EN to add the sticky framing-error output ferr.
`timescale 1ns/1ps

module rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    input  logic                 en,
    input  logic                 clr_rda,
    output logic [DATA_BITS-1:0] data,
    output logic                 rda
`ifdef RX_FERR_EN
    ,
    output logic                 ferr
`endif
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HalfLast = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FullLast = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BitLast  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } state_e;

    state_e               state_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 rda_q;
    logic                 sync1_q;
    logic                 rx_s;
`ifdef RX_FERR_EN
    logic                 ferr_q;
`endif

    // RxD is asynchronous to clk; idle-high reset value avoids a false start out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= RxD;
            rx_s    <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rda_q   <= 1'b0;
`ifdef RX_FERR_EN
            ferr_q  <= 1'b0;
`endif
        end else begin
            // Clears come first so a same-cycle load or framing error overrides them.
            if (clr_rda) begin
                rda_q  <= 1'b0;
`ifdef RX_FERR_EN
                ferr_q <= 1'b0;
`endif
            end
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        tick_q  <= '0;
                    end
                end
                StStart: begin
                    if (en) begin
                        if (tick_q == HalfLast) begin
                            tick_q <= '0;
                            if (!rx_s) begin
                                state_q <= StData;
                                bit_q   <= '0;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                StData: begin
                    if (en) begin
                        if (tick_q == FullLast) begin
                            tick_q  <= '0;
                            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == BitLast) begin
                                state_q <= StStop;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                StStop: begin
                    if (en) begin
                        if (tick_q == FullLast) begin
                            tick_q  <= '0;
                            state_q <= StIdle;
                            if (rx_s) begin
                                data_q <= shift_q;
                                rda_q  <= 1'b1;
                            end else begin
`ifdef RX_FERR_EN
                                ferr_q <= 1'b1;
`endif
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data = data_q;
    assign rda  = rda_q;
`ifdef RX_FERR_EN
    assign ferr = ferr_q;
`endif

endmodule

// File: tb/tb_rx.sv
// Scoreboard bench for rx: serial frames push expected bytes, a monitor pops them on each load.
`timescale 1ns/1ps

module tb_rx;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       RxD     = 1'b1;
    logic       en      = 1'b0;
    logic       clr_rda = 1'b0;
    logic [7:0] data;
    logic       rda;
`ifdef RX_FERR_EN
    logic       ferr;
`endif

    int         en_div = 4;
    int         checks = 0;
    int         errors = 0;
    int         loads  = 0;
    logic [7:0] exp_q[$];

    rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .RxD    (RxD),
        .en     (en),
        .clr_rda(clr_rda),
        .data   (data),
        .rda    (rda)
`ifdef RX_FERR_EN
        ,
        .ferr   (ferr)
`endif
    );

    always #5 clk = ~clk;

    initial begin : en_gen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cnt >= en_div - 1) begin
                cnt = 0;
                en  = 1'b1;
            end else begin
                cnt = cnt + 1;
                en  = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int bit_ns();
        return 160 * en_div;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bad stop bits are held low for 5/8 bit so the idle resync falls into a false start.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic push);
        int bt;
        bt = bit_ns();
        if (push) exp_q.push_back(b);
        RxD = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            #(bt);
        end
        if (stop_ok) begin
            RxD = 1'b1;
            #(bt);
        end else begin
            RxD = 1'b0;
            #(bt * 5 / 8);
            RxD = 1'b1;
            #(bt - bt * 5 / 8);
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_rda = 1'b1;
        @(posedge clk);
        #1 clr_rda = 1'b0;
    endtask

    task automatic monitor();
        logic       rda_p;
        logic [7:0] data_p;
        logic [7:0] e;
        rda_p  = 1'b0;
        data_p = 8'h00;
        forever begin
            @(negedge clk);
            if (rda && (!rda_p || data != data_p)) begin
                loads = loads + 1;
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL sb_unexpected_load: got %0h expected none at %0t", data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", int'(data), int'(e));
                end
            end
            rda_p  = rda;
            data_p = data;
        end
    endtask

    initial begin : main
        int n;
        int loads0;
        #23;
        check("reset_data", int'(data), 0);
        check("reset_rda", int'(rda), 0);
        check("reset_state", int'(dut.state_q), 0);
`ifdef RX_FERR_EN
        check("reset_ferr", int'(ferr), 0);
`endif
        #10 rst = 1'b0;
        fork
            monitor();
        join_none

        // 1: idle, then 0xA5
        #(bit_ns() * 10);
        send_byte(8'hA5, 1'b1, 1'b1);
        check("t1_rda", int'(rda), 1);
        check("t1_data", int'(data), 8'hA5);
        pulse_clr();
        @(negedge clk);
        check("t1_clr_rda", int'(rda), 0);
        check("t1_hold_data", int'(data), 8'hA5);

        // 2: false start, then 0x3C
        @(posedge clk);
        #3 RxD = 1'b0;
        repeat (20) @(posedge clk);
        #3 RxD = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("t2_rda", int'(rda), 0);
        check("t2_data", int'(data), 8'hA5);
        check("t2_idle", int'(dut.state_q), 0);
        send_byte(8'h3C, 1'b1, 1'b1);
        check("t2_rx_data", int'(data), 8'h3C);
        check("t2_rx_rda", int'(rda), 1);
        pulse_clr();

        // 3: bad stop bit
        send_byte(8'h3C, 1'b0, 1'b0);
        #(bit_ns());
        @(negedge clk);
        check("t3_rda", int'(rda), 0);
        check("t3_data", int'(data), 8'h3C);
        check("t3_idle", int'(dut.state_q), 0);
`ifdef RX_FERR_EN
        check("t3_ferr_set", int'(ferr), 1);
        pulse_clr();
        @(negedge clk);
        check("t3_ferr_clr", int'(ferr), 0);
`endif

        // 4: back-to-back overrun, then clr_rda on the load cycle
        send_byte(8'h55, 1'b1, 1'b1);
        send_byte(8'hAA, 1'b1, 1'b1);
        check("t4_overrun_data", int'(data), 8'hAA);
        check("t4_overrun_rda", int'(rda), 1);
        fork
            send_byte(8'h0F, 1'b1, 1'b1);
            begin
                n = 0;
                @(negedge clk);
                while (!(dut.state_q == 2'd3 && dut.tick_q == 4'd15 && en) && n < 20000) begin
                    @(negedge clk);
                    n = n + 1;
                end
                if (n >= 20000) begin
                    check("t4_load_cycle_timeout", n, 0);
                end else begin
                    clr_rda = 1'b1;
                    @(posedge clk);
                    #1 clr_rda = 1'b0;
                end
            end
        join
        @(negedge clk);
        check("t4_clr_vs_load_rda", int'(rda), 1);
        check("t4_clr_vs_load_data", int'(data), 8'h0F);
        pulse_clr();

        // 5: reset mid-frame, then 0x81
        fork
            send_byte(8'hFF, 1'b1, 1'b0);
            begin
                #(bit_ns() * 4 + bit_ns() / 2);
                rst = 1'b1;
                #1;
                check("t5_rst_data", int'(data), 0);
                check("t5_rst_rda", int'(rda), 0);
                check("t5_rst_state", int'(dut.state_q), 0);
`ifdef RX_FERR_EN
                check("t5_rst_ferr", int'(ferr), 0);
`endif
                #47 rst = 1'b0;
            end
        join
        #(bit_ns() * 2);
        send_byte(8'h81, 1'b1, 1'b1);
        check("t5_data", int'(data), 8'h81);
        check("t5_rda", int'(rda), 1);
        pulse_clr();

        // 6: continuous stream 0x00..0xFF at a faster tick rate
        en_div = 1;
        repeat (20) @(posedge clk);
        loads0 = loads;
        fork
            for (int b = 0; b < 256; b++) begin
                send_byte(8'(b), 1'b1, 1'b1);
            end
            for (int k = 0; k < 256; k++) begin
                n = 0;
                while (!rda && n < 1000) begin
                    @(negedge clk);
                    n = n + 1;
                end
                if (n >= 1000) check("t6_rda_timeout", k, -1);
                pulse_clr();
            end
        join
        repeat (50) @(posedge clk);
        check("t6_load_count", loads - loads0, 256);
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_last_data", int'(data), 8'hFF);
`ifdef RX_FERR_EN
        check("t6_ferr", int'(ferr), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
